// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default line-rate constants, parity helper.
// Latency: none (declarations only); backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 19_200;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Bit that makes the total count of ones (data plus parity) odd; narrower words are zero-extended.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-BAUD_DIV bit timer with synchronous clear; bit_end marks the last cycle of each bit.
// Latency: bit_end on the BAUD_DIV-th cycle after clear drops; backpressure: none, free-running.
module uart_baud_tick #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one start/data/odd-parity/stop frame per rising edge of the debounced send level.
// Latency: tx goes low the cycle after the edge is sampled; backpressure: edges seen while busy are dropped.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD      = DEF_BAUD,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t state, state_n;
  logic send_q, start_req, bit_end, clear;
  logic par_q, par_n, tx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IW-1:0] idx, idx_n;

  assign start_req = send & ~send_q;
  assign clear     = (state == IDLE);
  assign done      = (state == STOP) && bit_end;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    par_n   = par_q;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_n = START;
          shreg_n = din;
          idx_n   = '0;
          par_n   = odd_parity(8'(din));
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      send_q <= 1'b1;
      shreg  <= '0;
      idx    <= '0;
      par_q  <= 1'b0;
      tx     <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      send_q <= send;
      shreg  <= shreg_n;
      idx    <= idx_n;
      par_q  <= par_n;
      tx     <= tx_n;
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: scenario tasks compared cycle by cycle against a frame-layout reference model.
module tb_uart_tx_frame;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic send = 1'b0;
  logic send_np = 1'b0;
  logic [7:0] din = 8'h00;
  logic tx, busy, done;
  logic tx_np, busy_np, done_np;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(100), .BAUD(10), .DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .send(send), .din(din),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_frame #(.CLK_FREQ(100), .BAUD(10), .DATA_BITS(8), .PARITY_EN(0)) dut_np (
    .clk(clk), .reset(reset), .send(send_np), .din(din),
    .tx(tx_np), .busy(busy_np), .done(done_np)
  );

  // Reference model: j is the cycle count since the edge was sampled (j=1 is the first start-bit cycle).
  function automatic int m_len(input bit pe);
    return (2 + 8 + (pe ? 1 : 0)) * DIV;
  endfunction

  function automatic logic m_tx(input int j, input logic [7:0] d, input bit pe);
    int b;
    if (j < 1 || j > m_len(pe)) return 1'b1;
    b = (j - 1) / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) begin
      int ones;
      ones = 0;
      for (int k = 0; k < 8; k++) ones += d[k];
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int j, input bit pe);
    return (j >= 1 && j <= m_len(pe));
  endfunction

  function automatic logic m_done(input int j, input bit pe);
    return (j == m_len(pe));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (tx_np !== 1'b1) begin errors++; $display("FAIL reset_tx_np got %b exp 1", tx_np); end
    tick(); tick();
    reset = 1'b0;
    // button held across reset must not launch a frame
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_reset_busy j=%0d got %b exp 0", j, busy); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL held_reset_tx j=%0d got %b exp 1", j, tx); end
    end
    send = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'h41;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 120; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))     begin errors++; $display("FAIL basic_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1))    begin errors++; $display("FAIL basic_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      checks++; if (done !== m_done(j, 1))    begin errors++; $display("FAIL basic_done j=%0d got %b exp %b", j, done, m_done(j, 1)); end
      if (j == 3) send = 1'b0;
    end
  endtask

  task automatic test_held();
    logic [7:0] d;
    d = 8'hFF;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))  begin errors++; $display("FAIL held_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1)) begin errors++; $display("FAIL held_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      checks++; if (done !== m_done(j, 1)) begin errors++; $display("FAIL held_done j=%0d got %b exp %b", j, done, m_done(j, 1)); end
    end
    send = 1'b0;
    tick();
  endtask

  task automatic test_press_while_busy();
    logic [7:0] d;
    d = 8'h96;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))  begin errors++; $display("FAIL busy_press_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1)) begin errors++; $display("FAIL busy_press_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      if (j == 3) send = 1'b0;
      if (j == 39) send = 1'b1;
      if (j == 45) send = 1'b0;
    end
  endtask

  task automatic test_din_change();
    logic [7:0] d;
    d = 8'h00;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 130; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1)) begin errors++; $display("FAIL din_change_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      if (j == 3) send = 1'b0;
      if (j == 14) din = 8'hAA;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5B;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 55; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1)) begin errors++; $display("FAIL pre_reset_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
    end
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midreset_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done); end
    tick(); tick(); tick();
    reset = 1'b0;
    for (int j = 1; j <= 50; j++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy j=%0d got %b exp 0", j, busy); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL post_reset_tx j=%0d got %b exp 1", j, tx); end
    end
    send = 1'b0;
    tick();
    d = 8'h3C;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 115; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))  begin errors++; $display("FAIL after_reset_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1)) begin errors++; $display("FAIL after_reset_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      if (j == 3) send = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'hC5;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 110; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1)) begin errors++; $display("FAIL b2b_first_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      if (j == 3) send = 1'b0;
    end
    // edge lands in the done cycle (still STOP): must be ignored
    send = 1'b1;
    for (int j = 111; j <= 240; j++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_busy j=%0d got %b exp 0", j, busy); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL b2b_ignored_tx j=%0d got %b exp 1", j, tx); end
    end
    send = 1'b0;
    tick();
    d = 8'h0F;
    din = d;
    send = 1'b1;
    for (int j = 1; j <= 111; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))  begin errors++; $display("FAIL b2b_second_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1)) begin errors++; $display("FAIL b2b_second_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      if (j == 109) send = 1'b0;
      if (j == 111) send = 1'b1;
    end
    // earliest restart: edge sampled on the first IDLE cycle
    d = 8'hA3;
    din = d;
    for (int j = 1; j <= 112; j++) begin
      tick();
      checks++; if (tx !== m_tx(j, d, 1))  begin errors++; $display("FAIL b2b_third_tx j=%0d got %b exp %b", j, tx, m_tx(j, d, 1)); end
      checks++; if (busy !== m_busy(j, 1)) begin errors++; $display("FAIL b2b_third_busy j=%0d got %b exp %b", j, busy, m_busy(j, 1)); end
      checks++; if (done !== m_done(j, 1)) begin errors++; $display("FAIL b2b_third_done j=%0d got %b exp %b", j, done, m_done(j, 1)); end
      if (j == 3) send = 1'b0;
    end
  endtask

  task automatic test_no_parity();
    logic [7:0] d;
    d = 8'h80;
    din = d;
    send_np = 1'b1;
    for (int j = 1; j <= 110; j++) begin
      tick();
      checks++; if (tx_np !== m_tx(j, d, 0))  begin errors++; $display("FAIL nopar_tx j=%0d got %b exp %b", j, tx_np, m_tx(j, d, 0)); end
      checks++; if (busy_np !== m_busy(j, 0)) begin errors++; $display("FAIL nopar_busy j=%0d got %b exp %b", j, busy_np, m_busy(j, 0)); end
      checks++; if (done_np !== m_done(j, 0)) begin errors++; $display("FAIL nopar_done j=%0d got %b exp %b", j, done_np, m_done(j, 0)); end
      if (j == 3) send_np = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      logic [7:0] d;
      bit pe;
      int h, chg, len;
      logic otx, obusy, odone;
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 160);
      chg = $urandom_range(2, 100);
      len = m_len(pe);
      din = d;
      if (pe) send = 1'b1; else send_np = 1'b1;
      for (int j = 1; j <= len + 12; j++) begin
        tick();
        otx = pe ? tx : tx_np;
        obusy = pe ? busy : busy_np;
        odone = pe ? done : done_np;
        checks++; if (otx !== m_tx(j, d, pe))    begin errors++; $display("FAIL rand_tx f=%0d d=%h pe=%0d j=%0d got %b exp %b", f, d, pe, j, otx, m_tx(j, d, pe)); end
        checks++; if (obusy !== m_busy(j, pe))   begin errors++; $display("FAIL rand_busy f=%0d j=%0d got %b exp %b", f, j, obusy, m_busy(j, pe)); end
        checks++; if (odone !== m_done(j, pe))   begin errors++; $display("FAIL rand_done f=%0d j=%0d got %b exp %b", f, j, odone, m_done(j, pe)); end
        if (j == h) begin send = 1'b0; send_np = 1'b0; end
        if (j == chg) din = 8'($urandom);
      end
      send = 1'b0;
      send_np = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_press_while_busy();
    test_din_change();
    test_reset_mid_frame();
    test_back_to_back();
    test_no_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
